// File: rtl/etch_cursor_ctl.sv
// Etch-a-sketch cursor sequencer: rotary step accumulation, bounded cursor, pixel-write
// handshakes, full-screen erase sweep and X/Y display multiplexing. Optional macro: ETCH_WRAP_EN.
module etch_cursor_ctl #(
    parameter int X_W      = 8,
    parameter int Y_W      = 8,
    parameter int X_MAX    = 159,
    parameter int Y_MAX    = 119,
    parameter int X_HOME   = 80,
    parameter int Y_HOME   = 60,
    parameter int DISP_DIV = 25000000
) (
    input  logic           clk_clk,
    input  logic           reset_reset_n,
    input  logic           x_cw,
    input  logic           x_ccw,
    input  logic           y_cw,
    input  logic           y_ccw,
    input  logic           pen_down,
    input  logic           clear_req,
    output logic           pix_valid,
    input  logic           pix_ready,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           pix_color,
    output logic [X_W-1:0] cur_x,
    output logic [Y_W-1:0] cur_y,
    output logic           busy,
    output logic           ev_drop,
    output logic           disp_sel,
    output logic [7:0]     disp_val
);

    // pix_valid/pix_ready: a transfer happens on every rising edge where both are 1;
    // while pix_valid is 1 and pix_ready is 0, pix_x/pix_y/pix_color hold stable.
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

`ifdef ETCH_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam int DIV_W = (DISP_DIV > 2) ? $clog2(DISP_DIV) : 1;
    localparam logic [X_W-1:0]   LP_X_MAX  = X_W'(X_MAX);
    localparam logic [Y_W-1:0]   LP_Y_MAX  = Y_W'(Y_MAX);
    localparam logic [DIV_W-1:0] LP_DIV_END = DIV_W'(DISP_DIV - 1);
    localparam logic signed [1:0] P1 = 2'sb01;
    localparam logic signed [1:0] M1 = 2'sb11;
    localparam logic signed [1:0] Z0 = 2'sb00;

    state_t           r_state;
    logic [3:0]       r_pend_x, r_pend_y;
    logic             r_clr_pend;
    logic [DIV_W-1:0] r_div;
    logic [X_W-1:0]   r_cur_x, r_pix_x;
    logic [Y_W-1:0]   r_cur_y, r_pix_y;
    logic             r_pix_valid, r_pix_color, r_ev_drop, r_disp_sel;

    logic signed [1:0] w_dx, w_dy, w_tx, w_ty;
    logic signed [4:0] w_sum_x, w_sum_y;
    logic              w_sat_x, w_sat_y, w_take, w_moved;
    logic [3:0]        w_npend_x, w_npend_y;
    logic [X_W-1:0]    w_nx;
    logic [Y_W-1:0]    w_ny;
    logic [31:0]       w_cx32, w_cy32;

    assign w_dx = (x_cw & ~x_ccw) ? P1 : ((x_ccw & ~x_cw) ? M1 : Z0);
    assign w_dy = (y_cw & ~y_ccw) ? P1 : ((y_ccw & ~y_cw) ? M1 : Z0);

    // Takes only happen in IDLE when no erase is waiting; both axes move together.
    assign w_take = (r_state == S_IDLE) && !r_clr_pend && ((r_pend_x != 4'd0) || (r_pend_y != 4'd0));
    assign w_tx = (!w_take || r_pend_x == 4'd0) ? Z0 : (r_pend_x[3] ? M1 : P1);
    assign w_ty = (!w_take || r_pend_y == 4'd0) ? Z0 : (r_pend_y[3] ? M1 : P1);

    // Take always pulls toward zero, so overflow can only come from the new step.
    assign w_sum_x = {r_pend_x[3], r_pend_x} + {{3{w_dx[1]}}, w_dx} - {{3{w_tx[1]}}, w_tx};
    assign w_sum_y = {r_pend_y[3], r_pend_y} + {{3{w_dy[1]}}, w_dy} - {{3{w_ty[1]}}, w_ty};
    assign w_sat_x = (w_sum_x > 5'sd7) || (w_sum_x < -5'sd7);
    assign w_sat_y = (w_sum_y > 5'sd7) || (w_sum_y < -5'sd7);
    assign w_npend_x = w_sat_x ? (w_sum_x[4] ? 4'b1001 : 4'b0111) : w_sum_x[3:0];
    assign w_npend_y = w_sat_y ? (w_sum_y[4] ? 4'b1001 : 4'b0111) : w_sum_y[3:0];

    always_comb begin
        w_nx = r_cur_x;
        w_ny = r_cur_y;
        if (w_tx == P1)
            w_nx = (r_cur_x == LP_X_MAX) ? (WRAP ? '0 : r_cur_x) : r_cur_x + 1'b1;
        else if (w_tx == M1)
            w_nx = (r_cur_x == '0) ? (WRAP ? LP_X_MAX : r_cur_x) : r_cur_x - 1'b1;
        if (w_ty == P1)
            w_ny = (r_cur_y == LP_Y_MAX) ? (WRAP ? '0 : r_cur_y) : r_cur_y + 1'b1;
        else if (w_ty == M1)
            w_ny = (r_cur_y == '0) ? (WRAP ? LP_Y_MAX : r_cur_y) : r_cur_y - 1'b1;
    end

    assign w_moved = (w_nx != r_cur_x) || (w_ny != r_cur_y);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state     <= S_IDLE;
            r_pend_x    <= '0;
            r_pend_y    <= '0;
            r_clr_pend  <= 1'b0;
            r_div       <= '0;
            r_cur_x     <= X_W'(X_HOME);
            r_cur_y     <= Y_W'(Y_HOME);
            r_pix_valid <= 1'b0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_color <= 1'b0;
            r_ev_drop   <= 1'b0;
            r_disp_sel  <= 1'b0;
        end else begin
            r_pend_x   <= w_npend_x;
            r_pend_y   <= w_npend_y;
            r_ev_drop  <= r_ev_drop | w_sat_x | w_sat_y;
            r_clr_pend <= clear_req | (r_clr_pend & (r_state != S_IDLE));
            if (r_div == LP_DIV_END) begin
                r_div      <= '0;
                r_disp_sel <= ~r_disp_sel;
            end else begin
                r_div <= r_div + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_clr_pend) begin
                        r_state     <= S_CLEAR;
                        r_pix_valid <= 1'b1;
                        r_pix_x     <= '0;
                        r_pix_y     <= '0;
                        r_pix_color <= 1'b0;
                    end else if (w_take) begin
                        r_cur_x <= w_nx;
                        r_cur_y <= w_ny;
                        if (pen_down && w_moved) begin
                            r_state     <= S_WRITE;
                            r_pix_valid <= 1'b1;
                            r_pix_x     <= w_nx;
                            r_pix_y     <= w_ny;
                            r_pix_color <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (pix_ready) begin
                        r_state     <= S_IDLE;
                        r_pix_valid <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (pix_ready) begin
                        if (r_pix_x == LP_X_MAX && r_pix_y == LP_Y_MAX) begin
                            r_state     <= S_IDLE;
                            r_pix_valid <= 1'b0;
                        end else if (r_pix_x == LP_X_MAX) begin
                            r_pix_x <= '0;
                            r_pix_y <= r_pix_y + 1'b1;
                        end else begin
                            r_pix_x <= r_pix_x + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_pix_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pix_valid = r_pix_valid;
    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign pix_color = r_pix_color;
    assign cur_x     = r_cur_x;
    assign cur_y     = r_cur_y;
    assign busy      = (r_state != S_IDLE);
    assign ev_drop   = r_ev_drop;
    assign disp_sel  = r_disp_sel;

    assign w_cx32   = 32'(r_cur_x);
    assign w_cy32   = 32'(r_cur_y);
    assign disp_val = r_disp_sel ? w_cy32[7:0] : w_cx32[7:0];

endmodule

// File: tb/tb_etch_cursor_ctl.sv
// Self-checking bench for etch_cursor_ctl: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized rotary-step/pen/ready traffic.
module tb_etch_cursor_ctl;

    localparam int X_W = 8, Y_W = 8, X_MAX = 159, Y_MAX = 119;
    localparam int X_HOME = 80, Y_HOME = 60, DISP_DIV = 4;
    localparam int NPIX = (X_MAX + 1) * (Y_MAX + 1);
`ifdef ETCH_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic x_cw = 0, x_ccw = 0, y_cw = 0, y_ccw = 0, pen_down = 0, clear_req = 0, pix_ready = 0;
    logic           pix_valid, pix_color, busy, ev_drop, disp_sel;
    logic [X_W-1:0] pix_x, cur_x;
    logic [Y_W-1:0] pix_y, cur_y;
    logic [7:0]     disp_val;

    etch_cursor_ctl #(
        .X_W(X_W), .Y_W(Y_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
        .X_HOME(X_HOME), .Y_HOME(Y_HOME), .DISP_DIV(DISP_DIV)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .x_cw(x_cw), .x_ccw(x_ccw), .y_cw(y_cw), .y_ccw(y_ccw),
        .pen_down(pen_down), .clear_req(clear_req),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .cur_x(cur_x), .cur_y(cur_y), .busy(busy), .ev_drop(ev_drop),
        .disp_sel(disp_sel), .disp_val(disp_val)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [16:0] hs_q[$];  // accepted writes {color, x, y}

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    always @(posedge clk)
        if (rst_n && pix_valid && pix_ready) hs_q.push_back({pix_color, pix_x, pix_y});

    // ---------------- behavioural model ----------------
    int m_pend_x = 0, m_pend_y = 0, m_cx = X_HOME, m_cy = Y_HOME;
    int m_mode = 0;  // 0 idle, 1 single write, 2 erase sweep
    int m_idx = 0, m_px = 0, m_py = 0;
    bit m_pv = 0, m_pc = 0, m_drop = 0, m_clr = 0, m_sel = 0;
    int m_div = 0;
    bit chk_en = 1;

    function automatic int step_pos(input int c, input int t, input int mx);
        if (t > 0) return (c == mx) ? (WRAP ? 0 : mx) : c + 1;
        if (t < 0) return (c == 0) ? (WRAP ? mx : 0) : c - 1;
        return c;
    endfunction

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic int net(input logic up, input logic dn);
        return (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int dx, dy, tx, ty, nx, ny, s;
        if (!rst_n) begin
            m_pend_x = 0; m_pend_y = 0; m_cx = X_HOME; m_cy = Y_HOME;
            m_mode = 0; m_idx = 0; m_px = 0; m_py = 0;
            m_pv = 0; m_pc = 0; m_drop = 0; m_clr = 0; m_sel = 0; m_div = 0;
        end else begin
            dx = net(x_cw, x_ccw);
            dy = net(y_cw, y_ccw);
            tx = 0; ty = 0;
            if (m_mode == 0) begin
                if (m_clr) begin
                    m_clr = 0; m_mode = 2; m_idx = 0;
                    m_pv = 1; m_px = 0; m_py = 0; m_pc = 0;
                end else if (m_pend_x != 0 || m_pend_y != 0) begin
                    tx = sgn(m_pend_x); ty = sgn(m_pend_y);
                    nx = step_pos(m_cx, tx, X_MAX);
                    ny = step_pos(m_cy, ty, Y_MAX);
                    if (pen_down && (nx != m_cx || ny != m_cy)) begin
                        m_mode = 1; m_pv = 1; m_px = nx; m_py = ny; m_pc = 1;
                    end
                    m_cx = nx; m_cy = ny;
                end
            end else if (m_mode == 1) begin
                if (pix_ready) begin m_mode = 0; m_pv = 0; end
            end else begin
                if (pix_ready) begin
                    if (m_idx == NPIX - 1) begin
                        m_mode = 0; m_pv = 0;
                    end else begin
                        m_idx++;
                        m_px = m_idx % (X_MAX + 1);
                        m_py = m_idx / (X_MAX + 1);
                    end
                end
            end
            if (clear_req) m_clr = 1;
            s = m_pend_x + dx - tx;
            if (s > 7) begin s = 7; m_drop = 1; end
            else if (s < -7) begin s = -7; m_drop = 1; end
            m_pend_x = s;
            s = m_pend_y + dy - ty;
            if (s > 7) begin s = 7; m_drop = 1; end
            else if (s < -7) begin s = -7; m_drop = 1; end
            m_pend_y = s;
            if (m_div == DISP_DIV - 1) begin m_div = 0; m_sel = !m_sel; end
            else m_div++;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("cur_x", cur_x, m_cx);
            check("cur_y", cur_y, m_cy);
            check("pix_valid", pix_valid, m_pv);
            check("busy", busy, m_mode != 0);
            check("ev_drop", ev_drop, m_drop);
            check("disp_sel", disp_sel, m_sel);
            check("disp_val", disp_val, (m_sel ? m_cy : m_cx) & 255);
            if (m_pv) begin
                check("pix_x", pix_x, m_px);
                check("pix_y", pix_y, m_py);
                check("pix_color", pix_color, m_pc);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int n = 0;
        while (busy && n < budget) begin cyc(1); n++; end
        check(nm, busy, 0);
    endtask

    task automatic rand_cycles(input int n);
        repeat (n) begin
            x_cw  = ($urandom_range(0, 3) == 0);
            x_ccw = ($urandom_range(0, 3) == 0);
            y_cw  = ($urandom_range(0, 3) == 0);
            y_ccw = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 15) == 0) pen_down = !pen_down;
            pix_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end
        x_cw = 0; x_ccw = 0; y_cw = 0; y_ccw = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, t0;
        rst_n = 0;
        cyc(2);
        check("rst cur_x", cur_x, 80);
        check("rst cur_y", cur_y, 60);
        check("rst pix_valid", pix_valid, 0);
        check("rst pix_xyc", {pix_color, pix_x, pix_y}, 0);
        check("rst busy", busy, 0);
        check("rst ev_drop", ev_drop, 0);
        check("rst disp_sel", disp_sel, 0);
        rst_n = 1;
        cyc(2);

        // three x_cw steps with pen down
        pen_down = 1; pix_ready = 1; hs_q.delete();
        for (int i = 0; i < 3; i++) begin x_cw = 1; cyc(1); x_cw = 0; cyc(3); end
        cyc(4);
        check("t1 cur_x", cur_x, 83);
        check("t1 writes", hs_q.size(), 3);
        if (hs_q.size() == 3) begin
            check("t1 w0", hs_q[0], {1'b1, 8'd81, 8'd60});
            check("t1 w1", hs_q[1], {1'b1, 8'd82, 8'd60});
            check("t1 w2", hs_q[2], {1'b1, 8'd83, 8'd60});
        end

        // stalled framebuffer while y_ccw floods in
        hs_q.delete(); pix_ready = 0;
        for (int i = 0; i < 10; i++) begin y_ccw = 1; cyc(1); y_ccw = 0; cyc(1); end
        check("t2 held valid", pix_valid, 1);
        check("t2 held xy", {pix_x, pix_y}, {8'd83, 8'd59});
        check("t2 ev_drop", ev_drop, 1);
        pix_ready = 1;
        cyc(20);
        check("t2 cur_y", cur_y, 52);
        check("t2 writes", hs_q.size(), 8);
        if (hs_q.size() == 8) check("t2 last", hs_q[7], {1'b1, 8'd83, 8'd52});

        // walk to the right edge with pen up, then one more step with pen down
        pen_down = 0;
        for (int i = 0; i < 76; i++) begin x_cw = 1; cyc(1); x_cw = 0; cyc(1); end
        cyc(4);
        check("t3 at edge", cur_x, 159);
        hs_q.delete(); pen_down = 1;
        x_cw = 1; cyc(1); x_cw = 0; cyc(6);
        if (WRAP) begin
            check("t3 wrap cur_x", cur_x, 0);
            check("t3 wrap writes", hs_q.size(), 1);
            if (hs_q.size() == 1) check("t3 wrap w", hs_q[0], {1'b1, 8'd0, 8'd52});
        end else begin
            check("t3 clamp cur_x", cur_x, 159);
            check("t3 clamp writes", hs_q.size(), 0);
        end

        // full-screen erase
        hs_q.delete();
        clear_req = 1; cyc(1); clear_req = 0;
        cyc(3);
        check("t4 busy", busy, 1);
        wait_idle("t4 timeout", NPIX + 100);
        check("t4 writes", hs_q.size(), NPIX);
        if (hs_q.size() == NPIX) begin
            check("t4 first", hs_q[0], {1'b0, 8'd0, 8'd0});
            check("t4 row1", hs_q[161], {1'b0, 8'd1, 8'd1});
            check("t4 last", hs_q[NPIX-1], {1'b0, 8'd159, 8'd119});
        end
        check("t4 cur_x", cur_x, WRAP ? 0 : 159);
        check("t4 cur_y", cur_y, 52);

        // simultaneous cw/ccw cancels; display period
        hs_q.delete();
        x_cw = 1; x_ccw = 1; cyc(1); x_cw = 0; x_ccw = 0; cyc(4);
        check("t5 cancel cur_x", cur_x, WRAP ? 0 : 159);
        check("t5 cancel writes", hs_q.size(), 0);
        n = 0; t0 = disp_sel;
        while (disp_sel == t0 && n < 10) begin cyc(1); n++; end
        n = 0; t0 = disp_sel;
        while (disp_sel == t0 && n < 10) begin cyc(1); n++; end
        check("t5 disp period", n, 4);

        // randomized traffic
        rand_cycles(4000);
        pix_ready = 1;
        wait_idle("rand timeout", 50);

        // async reset in the middle of an erase sweep
        clear_req = 1; cyc(1); clear_req = 0;
        cyc(50);
        check("t6 mid-clear valid", pix_valid, 1);
        #2 rst_n = 0;
        #1;
        check("t6 rst valid", pix_valid, 0);
        check("t6 rst busy", busy, 0);
        check("t6 rst cur", {cur_x, cur_y}, {8'd80, 8'd60});
        check("t6 rst ev_drop", ev_drop, 0);
        cyc(2);
        rst_n = 1;
        cyc(2);
        rand_cycles(600);
        pix_ready = 1;
        wait_idle("final timeout", 50);
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
